pipe_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register for the 5-stage core, replacing the per-stage hand-written

---
 rtl/core_pkg.sv | 23 ++
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage core pipeline registers: stall levels,
// flush source indices, payload field offsets and instruction-field helpers.
package core_pkg;

  typedef enum logic {NOSTOP = 1'b0, STOP = 1'b1} stall_e;

  typedef enum int {FLUSH_JUMP = 0, FLUSH_INT = 1} flush_src_e;

  localparam int          PW_DFLT         = 192;
  localparam int          INST_OFFSET     = 64;
  localparam logic [6:0]  INST_TYPE_L     = 7'b0000011;
  localparam logic [4:0]  ZERO_REG        = 5'd0;
  localparam logic [1:0]  FLUSH_OVR_DFLT  = 2'b01 << FLUSH_INT;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment and
// reset beats both.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: opaque payload + valid, hold/bubble/flush
// resolution with override-capable flush sources, load-use hints and perf counters.
module pipe_stage_reg
  import core_pkg::*;
#(
  parameter int               PW          = PW_DFLT,
  parameter int               STAGE       = 2,
  parameter int               STALL_W     = 6,
  parameter int               N_FLUSH     = 2,
  parameter logic [N_FLUSH-1:0] FLUSH_OVR = FLUSH_OVR_DFLT,
  parameter logic [PW-1:0]    NOP_PAYLOAD = '0,
  parameter int               INST_LSB    = INST_OFFSET,
  parameter logic [6:0]       LOAD_OPC    = INST_TYPE_L,
  parameter int               CNT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic [N_FLUSH-1:0] flush_i,
  input  logic               valid_i,
  input  logic [PW-1:0]      payload_i,
  output logic               valid_o,
  output logic [PW-1:0]      payload_o,
  output logic               is_load_o,
  output logic [4:0]         rd_o,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   hold_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
);

  logic          hold, bubble, ovr, fl;
  logic [31:0]   inst_in;
  logic          valid_q, valid_d;
  logic [PW-1:0] payload_q, payload_d;
  logic          is_load_q, is_load_d;
  logic [4:0]    rd_q, rd_d;
  logic          hold_inc, bubble_inc, flush_inc;
  logic          unused_stall;

  // Only this stage and its downstream neighbour matter; the rest is folded away.
  assign unused_stall = ^stall_i;

  assign hold    = (stall_i[STAGE] == STOP) && (stall_i[STAGE+1] == STOP);
  assign bubble  = (stall_i[STAGE] == STOP) && (stall_i[STAGE+1] == NOSTOP);
  assign ovr     = |(flush_i & FLUSH_OVR);
  assign fl      = |flush_i;
  assign inst_in = payload_i[INST_LSB +: 32];

  always_comb begin
    valid_d    = valid_q;
    payload_d  = payload_q;
    is_load_d  = is_load_q;
    rd_d       = rd_q;
    hold_inc   = 1'b0;
    bubble_inc = 1'b0;
    flush_inc  = 1'b0;
    if (ovr || (!hold && (bubble || fl))) begin
      valid_d    = 1'b0;
      payload_d  = NOP_PAYLOAD;
      is_load_d  = 1'b0;
      rd_d       = ZERO_REG;
      bubble_inc = !ovr && bubble;
      flush_inc  = valid_q && (ovr || !bubble);
    end else if (hold) begin
      hold_inc = 1'b1;
    end else begin
      valid_d   = valid_i;
      payload_d = payload_i;
      is_load_d = valid_i && (opcode_of(inst_in) == LOAD_OPC);
      rd_d      = valid_i ? rd_of(inst_in) : ZERO_REG;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      payload_q <= NOP_PAYLOAD;
      is_load_q <= 1'b0;
      rd_q      <= ZERO_REG;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign is_load_o = is_load_q;
  assign rd_o      = rd_q;

  sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(hold_inc), .cnt_o(hold_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(bubble_inc), .cnt_o(bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(flush_inc), .cnt_o(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed scenarios then random traffic,
// expected state pushed at drive time and checked by an independent monitor.
module tb_pipe_stage_reg;

  localparam int PW    = 192;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic [5:0]       stall_i = '0;
  logic [1:0]       flush_i = '0;
  logic             valid_i = 1'b0;
  logic [PW-1:0]    payload_i = '0;
  logic             cnt_clr_i = 1'b0;
  logic             valid_o;
  logic [PW-1:0]    payload_o;
  logic             is_load_o;
  logic [4:0]       rd_o;
  logic [CNT_W-1:0] hold_cnt_o, bubble_cnt_o, flush_cnt_o;

  pipe_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .payload_i(payload_i), .valid_o(valid_o), .payload_o(payload_o),
    .is_load_o(is_load_o), .rd_o(rd_o), .cnt_clr_i(cnt_clr_i),
    .hold_cnt_o(hold_cnt_o), .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic          valid;
    logic [PW-1:0] payload;
    int            hcnt;
    int            bcnt;
    int            fcnt;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  logic          m_valid = 1'b0;
  logic [PW-1:0] m_payload = '0;
  int            m_h = 0, m_b = 0, m_f = 0;

  task automatic chk(input string tag, input string name, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s.%s got=%0h expected=%0h", tag, name, act, exp);
    end
  endtask

  function automatic int sat_inc(input int c);
    return (c < CMAX) ? c + 1 : CMAX;
  endfunction

  // Monitor: the DUT presents a registered result every edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      logic [31:0] inst;
      logic        exp_ld;
      logic [4:0]  exp_rd;
      e      = sb.pop_front();
      inst   = e.payload[95:64];
      exp_ld = e.valid && (inst[6:0] == 7'b0000011);
      exp_rd = e.valid ? inst[11:7] : 5'd0;
      chk(e.tag, "valid",   PW'(valid_o),      PW'(e.valid));
      chk(e.tag, "payload", payload_o,         e.payload);
      chk(e.tag, "is_load", PW'(is_load_o),    PW'(exp_ld));
      chk(e.tag, "rd",      PW'(rd_o),         PW'(exp_rd));
      chk(e.tag, "hold",    PW'(hold_cnt_o),   PW'(e.hcnt));
      chk(e.tag, "bubble",  PW'(bubble_cnt_o), PW'(e.bcnt));
      chk(e.tag, "flush",   PW'(flush_cnt_o),  PW'(e.fcnt));
    end
  end

  task automatic step(input logic rst, input logic [5:0] st, input logic [1:0] fl,
                      input logic v, input logic [PW-1:0] p, input logic clr,
                      input string tag);
    logic is_hold, is_bub, is_ovr, any_fl, kill;
    exp_t e;
    @(negedge clk);
    rst_i = rst; stall_i = st; flush_i = fl; valid_i = v; payload_i = p; cnt_clr_i = clr;
    is_hold = st[2] && st[3];
    is_bub  = st[2] && !st[3];
    is_ovr  = fl[1];
    any_fl  = |fl;
    if (rst) begin
      m_valid = 1'b0; m_payload = '0; m_h = 0; m_b = 0; m_f = 0;
    end else begin
      kill = 1'b0;
      if (is_ovr) begin
        kill = m_valid; m_valid = 1'b0; m_payload = '0;
      end else if (is_hold) begin
        m_h = sat_inc(m_h);
      end else if (is_bub) begin
        m_valid = 1'b0; m_payload = '0; m_b = sat_inc(m_b);
      end else if (any_fl) begin
        kill = m_valid; m_valid = 1'b0; m_payload = '0;
      end else begin
        m_valid = v; m_payload = p;
      end
      if (kill) m_f = sat_inc(m_f);
      if (clr) begin m_h = 0; m_b = 0; m_f = 0; end
    end
    e.tag = tag; e.valid = m_valid; e.payload = m_payload;
    e.hcnt = m_h; e.bcnt = m_b; e.fcnt = m_f;
    sb.push_back(e);
  endtask

  function automatic logic [PW-1:0] rand_payload(input logic [31:0] inst);
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    p[95:64] = inst;
    return p;
  endfunction

  initial begin
    logic [PW-1:0] lw_p, other_p;
    logic [31:0]   inst;
    logic [5:0]    st;
    logic [1:0]    fl;
    lw_p    = rand_payload(32'h00312083);
    other_p = rand_payload(32'h00a30133);

    step(1, 6'b000000, 2'b00, 1, lw_p, 0, "T1_reset");
    step(1, 6'b000000, 2'b00, 1, lw_p, 0, "T1_reset");
    step(0, 6'b000000, 2'b00, 1, lw_p, 0, "T2_advance");
    for (int i = 0; i < 3; i++) step(0, 6'b001100, 2'b00, 1, other_p, 0, "T3_hold");
    step(0, 6'b000100, 2'b00, 1, other_p, 0, "T4_bubble");
    step(0, 6'b000000, 2'b00, 1, lw_p, 0, "T5_load");
    step(0, 6'b001100, 2'b01, 1, other_p, 0, "T5_hold_jump");
    step(0, 6'b001100, 2'b10, 1, other_p, 0, "T5_hold_int");
    step(0, 6'b000000, 2'b01, 1, lw_p, 0, "T5_flush_empty");
    step(0, 6'b110000, 2'b00, 1, lw_p, 0, "ignored_bits");
    step(0, 6'b000000, 2'b01, 1, other_p, 0, "flush_jump");
    step(0, 6'b000000, 2'b00, 0, lw_p, 0, "advance_invalid");
    for (int i = 0; i < 20; i++) step(0, 6'b001100, 2'b00, 1, other_p, 0, "T6_sat");
    step(0, 6'b001100, 2'b00, 1, other_p, 1, "T6_clr");
    step(0, 6'b001100, 2'b00, 1, other_p, 0, "T6_after_clr");
    step(1, 6'b001100, 2'b00, 1, other_p, 0, "reset_mid_hold");
    step(0, 6'b001100, 2'b00, 1, other_p, 0, "hold_after_reset");

    for (int n = 0; n < 400; n++) begin
      inst = ($urandom_range(0, 2) == 0) ? {$urandom, 7'b0000011} >> 0 : $urandom;
      if ($urandom_range(0, 2) == 0) inst[6:0] = 7'b0000011;
      st = 6'($urandom);
      if ($urandom_range(0, 1) == 0) st[2] = 1'b0;
      fl = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      step($urandom_range(0, 60) == 0, st, fl, 1'($urandom), rand_payload(inst),
           $urandom_range(0, 30) == 0, "random");
    end

    step(0, 6'b000000, 2'b00, 0, '0, 0, "drain");
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
